// File: rtl/imm_ext_pipe.sv
// ============================================================================
// Module  : imm_ext_pipe
// Brief   : Immediate extender (sign/zero/upper/branch) feeding a 2-entry
//           result FIFO. Optional stall statistic: IMM_EXT_PIPE_STALL_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [15:0]      stall_cnt
);

    localparam logic [1:0] MODE_SEXT  = 2'b00;
    localparam logic [1:0] MODE_ZEXT  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;

    logic [1:0]       count_q, count_d;
    logic [OUT_W-1:0] ent0_q, ent0_d;
    logic [OUT_W-1:0] ent1_q, ent1_d;
    logic [OUT_W-1:0] sext_w;
    logic [OUT_W-1:0] ext_w;
    logic             push_w;
    logic             pop_w;

    assign sext_w = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        ext_w = '0;
        case (in_mode)
            MODE_SEXT:  ext_w = sext_w;
            MODE_ZEXT:  ext_w = {{(OUT_W-IN_W){1'b0}}, in_imm};
            MODE_UPPER: ext_w = {in_imm, {(OUT_W-IN_W){1'b0}}};
            default:    ext_w = {sext_w[OUT_W-3:0], 2'b00};
        endcase
    end

    // Handshake flags come only from registered occupancy; in_ready never
    // looks at out_ready, so there is no combinational ready path.
    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? ent0_q : '0;
    assign push_w    = in_valid && in_ready;
    assign pop_w     = out_valid && out_ready;

    // ent0 is always the head; a pop at count 2 shifts ent1 forward.
    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (count_q)
            2'd0: begin
                if (push_w) begin
                    ent0_d  = ext_w;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_w && pop_w) begin
                    ent0_d = ext_w;
                end else if (push_w) begin
                    ent1_d  = ext_w;
                    count_d = 2'd2;
                end else if (pop_w) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop_w) begin
                    ent0_d  = ent1_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

`ifdef IMM_EXT_PIPE_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

`default_nettype wire
